// File: rtl/pc_gen_ras_if.sv
// Signal bundle between the D-stage control and the fetch-address unit.
// There is no handshake. Every input is sampled on every rising edge, and stall is the only flow control.
interface pc_gen_ras_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             stall;
    logic [WIDTH-1:0] D_pc;
    logic [25:0]      imm26;
    logic [WIDTH-1:0] rsRD1;
    logic [2:0]       Br;
    logic             b_jump;
    logic             link;
    logic             ret;
    logic             exc_req;
    logic             eret;
    logic [WIDTH-1:0] epc;
    logic [WIDTH-1:0] F_pc;
    logic [WIDTH-1:0] npc;
    logic [WIDTH-1:0] ras_top;
    logic             ras_valid;
    logic [CNT_W-1:0] ras_hit_cnt;
    logic [CNT_W-1:0] ras_miss_cnt;

    modport master (
        output stall, D_pc, imm26, rsRD1, Br, b_jump, link, ret, exc_req, eret, epc,
        input  F_pc, npc, ras_top, ras_valid, ras_hit_cnt, ras_miss_cnt
    );

    modport slave (
        input  stall, D_pc, imm26, rsRD1, Br, b_jump, link, ret, exc_req, eret, epc,
        output F_pc, npc, ras_top, ras_valid, ras_hit_cnt, ras_miss_cnt
    );
endinterface

// File: rtl/pc_gen_ras.sv
// Fetch PC register with next-PC selection, exception/ERET redirect and stall hold.
// It also holds a shadow return-address stack that scores jr $31 predictions without steering fetch.
module pc_gen_ras #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = 'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_VEC   = 'h0000_4180,
    parameter int               RAS_DEPTH = 4,
    parameter int               CNT_W     = 16
) (
    input logic         clk,
    input logic         reset,
    pc_gen_ras_if.slave bus
);
    localparam int             PTR_W = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0] FULL  = (PTR_W + 1)'(RAS_DEPTH);

    logic [WIDTH-1:0] f_pc_q;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] pc4;
    logic [WIDTH-1:0] br_off;
    logic [WIDTH-1:0] br_tgt;
    logic [WIDTH-1:0] j_tgt;

    assign pc4    = f_pc_q + WIDTH'(4);
    assign br_off = {{(WIDTH - 18){bus.imm26[15]}}, bus.imm26[15:0], 2'b00};
    assign br_tgt = bus.D_pc + WIDTH'(4) + br_off;

    generate
        if (WIDTH > 28) begin : g_jhi
            assign j_tgt = {bus.D_pc[WIDTH-1:28], bus.imm26, 2'b00};
        end else begin : g_jlo
            assign j_tgt = {bus.imm26, 2'b00};
        end
    endgenerate

    // A not-taken branch and the undefined Br codes both fall through to F_pc+4.
    always_comb begin
        next_pc = pc4;
        if (bus.exc_req)                         next_pc = EXC_VEC;
        else if (bus.eret)                       next_pc = bus.epc;
        else if (bus.Br == 3'd1 && bus.b_jump)   next_pc = br_tgt;
        else if (bus.Br == 3'd2)                 next_pc = j_tgt;
        else if (bus.Br == 3'd3)                 next_pc = bus.rsRD1;
    end

    always_ff @(posedge clk) begin
        if (reset)                                       f_pc_q <= RESET_PC;
        else if (bus.exc_req || bus.eret || !bus.stall)  f_pc_q <= next_pc;
    end

    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0] sp_q, sp_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0] hit_q, hit_d;
    logic [CNT_W-1:0] miss_q, miss_d;
    logic [PTR_W-1:0] top_idx;
    logic [WIDTH-1:0] top_val;
    logic             act;
    logic             ras_we;
    logic [PTR_W-1:0] ras_widx;

    assign top_idx = sp_q - PTR_W'(1);
    assign top_val = ras_q[top_idx];
    assign act     = !reset && !bus.stall && !bus.exc_req && !bus.eret;

    // The pop is resolved first, so a combined pop and push rewrites the slot that was just vacated.
    always_comb begin
        sp_d     = sp_q;
        cnt_d    = cnt_q;
        hit_d    = hit_q;
        miss_d   = miss_q;
        ras_we   = 1'b0;
        ras_widx = sp_q;
        if (act && bus.ret) begin
            if (cnt_q != '0) begin
                if (top_val == bus.rsRD1) hit_d  = (hit_q  == '1) ? hit_q  : hit_q  + CNT_W'(1);
                else                      miss_d = (miss_q == '1) ? miss_q : miss_q + CNT_W'(1);
                sp_d  = sp_q - PTR_W'(1);
                cnt_d = cnt_q - (PTR_W + 1)'(1);
            end else begin
                miss_d = (miss_q == '1) ? miss_q : miss_q + CNT_W'(1);
            end
        end
        if (act && bus.link) begin
            ras_we   = 1'b1;
            ras_widx = sp_d;
            sp_d     = sp_d + PTR_W'(1);
            cnt_d    = (cnt_d == FULL) ? FULL : cnt_d + (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_q   <= '0;
            cnt_q  <= '0;
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            sp_q   <= sp_d;
            cnt_q  <= cnt_d;
            hit_q  <= hit_d;
            miss_q <= miss_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ras_we) ras_q[ras_widx] <= bus.D_pc + WIDTH'(8);
    end

    assign bus.F_pc         = f_pc_q;
    assign bus.npc          = next_pc;
    assign bus.ras_top      = top_val;
    assign bus.ras_valid    = (cnt_q != '0);
    assign bus.ras_hit_cnt  = hit_q;
    assign bus.ras_miss_cnt = miss_q;
endmodule

// File: tb/tb_pc_gen_ras.sv
// Bench for pc_gen_ras. It runs directed plan sequences and then random traffic against a queue-based model.
// A second instance with 2-bit counters shares the same stimulus, so counter saturation is covered too.
module tb_pc_gen_ras;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    pc_gen_ras_if #(.WIDTH(32), .CNT_W(16)) bus ();
    pc_gen_ras_if #(.WIDTH(32), .CNT_W(2))  bus2 ();

    pc_gen_ras #(.WIDTH(32), .RESET_PC(32'h3000), .EXC_VEC(32'h4180), .RAS_DEPTH(4), .CNT_W(16))
        dut (.clk(clk), .reset(rst), .bus(bus));
    pc_gen_ras #(.WIDTH(32), .RESET_PC(32'h3000), .EXC_VEC(32'h4180), .RAS_DEPTH(4), .CNT_W(2))
        dut2 (.clk(clk), .reset(rst), .bus(bus2));

    assign bus2.stall   = bus.stall;
    assign bus2.D_pc    = bus.D_pc;
    assign bus2.imm26   = bus.imm26;
    assign bus2.rsRD1   = bus.rsRD1;
    assign bus2.Br      = bus.Br;
    assign bus2.b_jump  = bus.b_jump;
    assign bus2.link    = bus.link;
    assign bus2.ret     = bus.ret;
    assign bus2.exc_req = bus.exc_req;
    assign bus2.eret    = bus.eret;
    assign bus2.epc     = bus.epc;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model: the stack is an unbounded queue, trimmed from the oldest end
    logic [31:0] m_pc;
    logic [31:0] m_stack[$];
    int          m_hit, m_miss, m_hit2, m_miss2;
    logic [31:0] exp_q[$];
    logic [31:0] last_npc;

    function automatic logic [31:0] model_npc();
        logic [31:0] off;
        off = {{14{bus.imm26[15]}}, bus.imm26[15:0], 2'b00};
        if (bus.exc_req)                     return 32'h4180;
        if (bus.eret)                        return bus.epc;
        if (bus.Br == 3'd1 && bus.b_jump)    return bus.D_pc + 32'd4 + off;
        if (bus.Br == 3'd2)                  return {bus.D_pc[31:28], bus.imm26, 2'b00};
        if (bus.Br == 3'd3)                  return bus.rsRD1;
        return m_pc + 32'd4;
    endfunction

    task automatic count_hit(input bit hit);
        if (hit) begin
            if (m_hit  < 65535) m_hit++;
            if (m_hit2 < 3)     m_hit2++;
        end else begin
            if (m_miss  < 65535) m_miss++;
            if (m_miss2 < 3)     m_miss2++;
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h3000;
        m_stack.delete();
        m_hit = 0; m_miss = 0; m_hit2 = 0; m_miss2 = 0;
    endtask

    task automatic model_edge();
        logic [31:0] nx;
        bit          act;
        nx = model_npc();
        if (rst) begin
            model_reset();
        end else begin
            if (bus.exc_req || bus.eret || !bus.stall) m_pc = nx;
            act = !bus.stall && !bus.exc_req && !bus.eret;
            if (act && bus.ret) begin
                if (m_stack.size() > 0) begin
                    count_hit(m_stack[$] == bus.rsRD1);
                    void'(m_stack.pop_back());
                end else begin
                    count_hit(1'b0);
                end
            end
            if (act && bus.link) begin
                m_stack.push_back(bus.D_pc + 32'd8);
                if (m_stack.size() > 4) void'(m_stack.pop_front());
            end
        end
        exp_q.push_back(m_pc);
    endtask

    // scoreboard
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state();
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check_eq("exp_q_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq("F_pc", bus.F_pc, e);
        end
        check_eq("ras_valid", 32'(bus.ras_valid), 32'(m_stack.size() != 0));
        if (m_stack.size() != 0) check_eq("ras_top", bus.ras_top, m_stack[$]);
        check_eq("hit_cnt",   32'(bus.ras_hit_cnt),   32'(m_hit));
        check_eq("miss_cnt",  32'(bus.ras_miss_cnt),  32'(m_miss));
        check_eq("hit_cnt2",  32'(bus2.ras_hit_cnt),  32'(m_hit2));
        check_eq("miss_cnt2", 32'(bus2.ras_miss_cnt), 32'(m_miss2));
    endtask

    // driver: call at a falling edge; checks npc, clocks one edge, then checks the registered state
    task automatic step(input logic st, input logic [31:0] dpc, input logic [25:0] im,
                        input logic [31:0] rs, input logic [2:0] br, input logic bj,
                        input logic lk, input logic rt, input logic ex, input logic er,
                        input logic [31:0] ep);
        bus.stall = st; bus.D_pc = dpc; bus.imm26 = im; bus.rsRD1 = rs; bus.Br = br;
        bus.b_jump = bj; bus.link = lk; bus.ret = rt; bus.exc_req = ex; bus.eret = er;
        bus.epc = ep;
        #1;
        check_eq("npc", bus.npc, model_npc());
        last_npc = bus.npc;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_state();
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 26'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        logic        st, bj, lk, rt, ex, er;
        logic [31:0] dpc, rs, ep;
        logic [25:0] im;
        logic [2:0]  br;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.stall = 1'b0; bus.D_pc = '0; bus.imm26 = '0; bus.rsRD1 = '0; bus.Br = '0;
        bus.b_jump = 1'b0; bus.link = 1'b0; bus.ret = 1'b0; bus.exc_req = 1'b0;
        bus.eret = 1'b0; bus.epc = '0;
        repeat (2) @(posedge clk);
        model_reset();
        exp_q.push_back(m_pc);
        @(negedge clk);
        rst = 1'b0;
        check_state();
        check_eq("plan_reset_pc", bus.F_pc, 32'h3000);

        repeat (3) idle();
        check_eq("plan_seq", bus.F_pc, 32'h300C);

        step(1'b0, 32'h3010, 26'h000FFFE, 32'h0, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("plan_br_taken", last_npc, 32'h300C);
        step(1'b0, 32'h3010, 26'h000FFFE, 32'h0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("plan_br_not", last_npc, 32'h3010);
        step(1'b0, 32'h3010, 26'h0000C40, 32'h0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("plan_j26", last_npc, 32'h3100);

        repeat (2) step(1'b1, 32'h0, 26'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("plan_stall", bus.F_pc, 32'h3100);
        step(1'b1, 32'h0, 26'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("plan_exc", bus.F_pc, 32'h4180);
        step(1'b0, 32'h0, 26'h0, 32'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3020);
        check_eq("plan_eret", bus.F_pc, 32'h3020);

        step(1'b0, 32'h3000, 26'h0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("plan_push_top", bus.ras_top, 32'h3008);
        step(1'b0, 32'h3004, 26'h0, 32'h3008, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("plan_hit", 32'(bus.ras_hit_cnt), 32'd1);
        step(1'b0, 32'h3004, 26'h0, 32'h3008, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("plan_empty_miss", 32'(bus.ras_miss_cnt), 32'd1);

        for (int i = 0; i < 5; i++)
            step(1'b0, 32'h3000 + 32'(i) * 32'h10, 26'h0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("plan_ovf_top", bus.ras_top, 32'h3048);
        for (int i = 0; i < 4; i++)
            step(1'b0, 32'h0, 26'h0, 32'h3048 - 32'(i) * 32'h10, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("plan_ovf_hits", 32'(bus.ras_hit_cnt), 32'd5);
        step(1'b0, 32'h0, 26'h0, 32'h3008, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("plan_ovf_miss", 32'(bus.ras_miss_cnt), 32'd2);

        step(1'b1, 32'h3000, 26'h0, 32'h0, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("plan_frozen", 32'(bus.ras_valid), 32'd0);
        step(1'b0, 32'h3000, 26'h0, 32'h0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 32'h3100, 26'h0, 32'h3008, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("plan_combo_top", bus.ras_top, 32'h3108);
        check_eq("plan_combo_hit", 32'(bus.ras_hit_cnt), 32'd6);
        repeat (3) step(1'b0, 32'h0, 26'h0, 32'h0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("plan_sat_miss", 32'(bus2.ras_miss_cnt), 32'd3);
        check_eq("plan_sat_hit", 32'(bus2.ras_hit_cnt), 32'd3);

        for (int i = 0; i < 400; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            ex  = ($urandom_range(0, 15) == 0);
            er  = ($urandom_range(0, 15) == 0);
            dpc = 32'h3000 + (32'($urandom_range(0, 255)) << 2);
            im  = 26'($urandom);
            br  = 3'($urandom_range(0, 7));
            bj  = 1'($urandom_range(0, 1));
            lk  = ($urandom_range(0, 2) == 0);
            rt  = ($urandom_range(0, 2) == 0);
            ep  = 32'h3000 + (32'($urandom_range(0, 255)) << 2);
            if (m_stack.size() > 0 && $urandom_range(0, 1) == 1) rs = m_stack[$];
            else rs = 32'h3000 + (32'($urandom_range(0, 255)) << 2);
            rst = ($urandom_range(0, 49) == 0);
            step(st, dpc, im, rs, br, bj, lk, rt, ex, er, ep);
            rst = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
